// File: rtl/aux_peak_meter.sv
// aux_peak_meter
//
// Per-address peak-magnitude table fed by the DSP core auxiliary output bus.
// Every aux write folds |sample| into table[addr] (max-hold). The host reads
// an entry with clear-on-read semantics so level meters can be driven from
// AUXOUT instructions without stalling the core.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   aux_in_addr/data/en : aux write bus (data is signed)
//   clear_all           : pulse, zero the whole table (restarts a running sweep)
//   host_rd_req/addr    : read request, taken only while host_rd_ready is 1
//   host_rd_ready       : a request can be accepted this cycle
//   host_rd_ack         : one-cycle pulse, host_rd_data is valid
//   host_rd_data        : returned peak magnitude, held until the next ack
//   busy                : clear sweep in progress
//   aux_dropped         : sticky, an aux write arrived during a sweep
//
// state   | meaning
// --------+----------------------------------------------------------------
// CLEAR   | sweeping addresses 0..DEPTH-1 to zero, aux writes are discarded
// IDLE    | ready for a host read request
// PENDING | request latched, waiting for a cycle with aux_in_en = 0
// SERVE   | read-and-clear op in the pipeline, ack follows
//
// Aux pipeline: S1 registers addr and magnitude, S2 reads the table, S3
// writes max(old, mag). S3 forwards its write value into the S2 read so that
// back-to-back writes to one address never lose an update. A host read is
// injected into S1 in the service cycle as a "clear" op: its S2 read is the
// snapshot and its S3 write stores 0, which the forward path also hands to
// any aux write that follows it to the same address.

module aux_peak_meter #(
  parameter int AUX_ADDR_WIDTH = 8,
  parameter int SAMPLE_WIDTH   = 36,
  parameter int PEAK_WIDTH     = SAMPLE_WIDTH - 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [AUX_ADDR_WIDTH-1:0]      aux_in_addr,
  input  logic signed [SAMPLE_WIDTH-1:0] aux_in_data,
  input  logic                           aux_in_en,
  input  logic                           clear_all,
  input  logic                           host_rd_req,
  input  logic [AUX_ADDR_WIDTH-1:0]      host_rd_addr,
  output logic                           host_rd_ready,
  output logic                           host_rd_ack,
  output logic [PEAK_WIDTH-1:0]          host_rd_data,
  output logic                           busy,
  output logic                           aux_dropped
);

  localparam int DEPTH = 2 ** AUX_ADDR_WIDTH;
  localparam logic [AUX_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PENDING = 2'd2,
    ST_SERVE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [AUX_ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [AUX_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  // stage 1
  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_clr_q, s1_clr_d;
  logic [AUX_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [PEAK_WIDTH-1:0]     s1_mag_q, s1_mag_d;

  // stage 2 results, consumed by stage 3
  logic                      s2_valid_q, s2_valid_d;
  logic                      s2_clr_q, s2_clr_d;
  logic [AUX_ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
  logic [PEAK_WIDTH-1:0]     s2_mag_q, s2_mag_d;
  logic [PEAK_WIDTH-1:0]     s2_old_q, s2_old_d;

  logic                      host_rd_ack_q, host_rd_ack_d;
  logic [PEAK_WIDTH-1:0]     host_rd_data_q, host_rd_data_d;
  logic                      aux_dropped_q, aux_dropped_d;

  logic [PEAK_WIDTH-1:0]     peak_mem [DEPTH];

  logic                      mem_we;
  logic [AUX_ADDR_WIDTH-1:0] mem_waddr;
  logic [PEAK_WIDTH-1:0]     mem_wdata;

  logic [SAMPLE_WIDTH-1:0]   data_u;
  logic [SAMPLE_WIDTH-1:0]   abs_full;
  logic [PEAK_WIDTH-1:0]     aux_mag;
  logic [PEAK_WIDTH-1:0]     s3_new;
  logic                      fwd_hit;
  logic [PEAK_WIDTH-1:0]     rd_value;

  // Magnitude. Only the most negative sample leaves the top bit set after
  // negation; it saturates to the largest representable peak.
  always_comb begin
    data_u   = aux_in_data;
    abs_full = data_u;
    if (data_u[SAMPLE_WIDTH-1]) begin
      abs_full = ~data_u + SAMPLE_WIDTH'(1);
    end
    if (abs_full[SAMPLE_WIDTH-1]) begin
      aux_mag = '1;
    end else begin
      aux_mag = abs_full[PEAK_WIDTH-1:0];
    end
  end

  // Stage 3 value and the S3 -> S2 forward path.
  always_comb begin
    s3_new = '0;
    if (!s2_clr_q) begin
      s3_new = (s2_old_q > s2_mag_q) ? s2_old_q : s2_mag_q;
    end
    fwd_hit  = s2_valid_q && (s2_addr_q == s1_addr_q);
    rd_value = fwd_hit ? s3_new : peak_mem[s1_addr_q];
  end

  always_comb begin
    state_d        = state_q;
    clr_addr_d     = clr_addr_q;
    rd_addr_d      = rd_addr_q;
    host_rd_ready  = 1'b0;
    busy           = 1'b0;

    s1_valid_d     = 1'b0;
    s1_clr_d       = 1'b0;
    s1_addr_d      = aux_in_addr;
    s1_mag_d       = aux_mag;

    s2_valid_d     = s1_valid_q;
    s2_clr_d       = s1_clr_q;
    s2_addr_d      = s1_addr_q;
    s2_mag_d       = s1_mag_q;
    s2_old_d       = rd_value;

    host_rd_ack_d  = 1'b0;
    host_rd_data_d = host_rd_data_q;
    aux_dropped_d  = aux_dropped_q;

    mem_we         = s2_valid_q;
    mem_waddr      = s2_addr_q;
    mem_wdata      = s3_new;

    case (state_q)
      ST_CLEAR: begin
        busy       = 1'b1;
        s2_valid_d = 1'b0;
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + AUX_ADDR_WIDTH'(1);
        if (aux_in_en) begin
          aux_dropped_d = 1'b1;
        end
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        host_rd_ready = 1'b1;
        s1_valid_d    = aux_in_en;
        if (host_rd_req) begin
          rd_addr_d = host_rd_addr;
          state_d   = ST_PENDING;
        end
      end

      ST_PENDING: begin
        if (aux_in_en) begin
          s1_valid_d = 1'b1;
        end else begin
          // Free slot: inject the read-and-clear op in place of an aux write.
          s1_valid_d = 1'b1;
          s1_clr_d   = 1'b1;
          s1_addr_d  = rd_addr_q;
          s1_mag_d   = '0;
          state_d    = ST_SERVE;
        end
      end

      ST_SERVE: begin
        s1_valid_d = aux_in_en;
        if (s1_valid_q && s1_clr_q) begin
          host_rd_ack_d  = 1'b1;
          host_rd_data_d = rd_value;
        end
        if (host_rd_ack_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // clear_all flushes the pipeline so no in-flight write can land behind
    // the sweep, and abandons any read before it is acked.
    if (clear_all) begin
      state_d        = ST_CLEAR;
      clr_addr_d     = '0;
      s1_valid_d     = 1'b0;
      s2_valid_d     = 1'b0;
      host_rd_ack_d  = 1'b0;
      host_rd_data_d = host_rd_data_q;
      aux_dropped_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_CLEAR;
      clr_addr_q     <= '0;
      rd_addr_q      <= '0;
      s1_valid_q     <= 1'b0;
      s1_clr_q       <= 1'b0;
      s1_addr_q      <= '0;
      s1_mag_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_clr_q       <= 1'b0;
      s2_addr_q      <= '0;
      s2_mag_q       <= '0;
      s2_old_q       <= '0;
      host_rd_ack_q  <= 1'b0;
      host_rd_data_q <= '0;
      aux_dropped_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_addr_q     <= clr_addr_d;
      rd_addr_q      <= rd_addr_d;
      s1_valid_q     <= s1_valid_d;
      s1_clr_q       <= s1_clr_d;
      s1_addr_q      <= s1_addr_d;
      s1_mag_q       <= s1_mag_d;
      s2_valid_q     <= s2_valid_d;
      s2_clr_q       <= s2_clr_d;
      s2_addr_q      <= s2_addr_d;
      s2_mag_q       <= s2_mag_d;
      s2_old_q       <= s2_old_d;
      host_rd_ack_q  <= host_rd_ack_d;
      host_rd_data_q <= host_rd_data_d;
      aux_dropped_q  <= aux_dropped_d;
    end
  end

  // Table contents are not reset; the CLEAR sweep after reset zeroes them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      peak_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign host_rd_ack  = host_rd_ack_q;
  assign host_rd_data = host_rd_data_q;
  assign aux_dropped  = aux_dropped_q;

endmodule

// File: tb/tb_aux_peak_meter.sv
module tb_aux_peak_meter;

  logic               clk = 1'b0;
  logic               reset;
  logic [7:0]         aux_in_addr;
  logic signed [35:0] aux_in_data;
  logic               aux_in_en;
  logic               clear_all;
  logic               host_rd_req;
  logic [7:0]         host_rd_addr;
  logic               host_rd_ready;
  logic               host_rd_ack;
  logic [34:0]        host_rd_data;
  logic               busy;
  logic               aux_dropped;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] PEAK_MAX = 64'd34359738367;  // 2^35 - 1

  aux_peak_meter dut (
    .clk           (clk),
    .reset         (reset),
    .aux_in_addr   (aux_in_addr),
    .aux_in_data   (aux_in_data),
    .aux_in_en     (aux_in_en),
    .clear_all     (clear_all),
    .host_rd_req   (host_rd_req),
    .host_rd_addr  (host_rd_addr),
    .host_rd_ready (host_rd_ready),
    .host_rd_ack   (host_rd_ack),
    .host_rd_data  (host_rd_data),
    .busy          (busy),
    .aux_dropped   (aux_dropped)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aux_write(input logic [7:0] addr, input logic signed [35:0] data);
    aux_in_en   = 1'b1;
    aux_in_addr = addr;
    aux_in_data = data;
    tick();
    aux_in_en   = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] addr, output logic [34:0] data, output int lat);
    int n;
    n = 0;
    while (!host_rd_ready && n < 20) begin
      tick();
      n++;
    end
    check_val("rd_ready_wait", host_rd_ready, 1);
    host_rd_req  = 1'b1;
    host_rd_addr = addr;
    tick();
    host_rd_req  = 1'b0;
    lat = 1;
    while (!host_rd_ack && lat < 40) begin
      tick();
      lat++;
    end
    check_val("rd_ack_seen", host_rd_ack, 1);
    data = host_rd_data;
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 255; i++) begin
      tick();
    end
    check_val({tag, "_busy_255"}, busy, 1);
    check_val({tag, "_ready_255"}, host_rd_ready, 0);
    tick();
    check_val({tag, "_busy_256"}, busy, 0);
    check_val({tag, "_ready_256"}, host_rd_ready, 1);
  endtask

  initial begin
    logic [34:0] rd;
    int          lat;
    int          n;
    int          acks;

    reset        = 1'b1;
    aux_in_addr  = '0;
    aux_in_data  = '0;
    aux_in_en    = 1'b0;
    clear_all    = 1'b0;
    host_rd_req  = 1'b0;
    host_rd_addr = '0;

    tick();
    tick();
    check_val("rst_busy", busy, 1);
    check_val("rst_ready", host_rd_ready, 0);
    check_val("rst_ack", host_rd_ack, 0);
    check_val("rst_data", host_rd_data, 0);
    check_val("rst_dropped", aux_dropped, 0);

    reset = 1'b0;
    sweep_check("init");

    // empty table, best-case latency
    host_read(8'd5, rd, lat);
    check_val("rd5_data", rd, 0);
    check_val("rd5_lat", lat, 3);
    check_val("rd5_ready_at_ack", host_rd_ready, 0);
    tick();
    check_val("rd5_ready_after", host_rd_ready, 1);
    check_val("rd5_ack_pulse", host_rd_ack, 0);

    // back-to-back same-address writes, read immediately after
    aux_in_en = 1'b1; aux_in_addr = 8'd3;
    aux_in_data = 36'sd1000;  tick();
    aux_in_data = -36'sd3000; tick();
    aux_in_data = 36'sd2000;  tick();
    aux_in_en = 1'b0;
    host_read(8'd3, rd, lat);
    check_val("rd3_data", rd, 3000);
    check_val("rd3_lat", lat, 3);
    tick();
    host_read(8'd3, rd, lat);
    check_val("rd3_cleared", rd, 0);
    check_val("rd3b_lat", lat, 3);

    // magnitude extremes
    aux_write(8'd7, 36'sh8_0000_0000);
    aux_write(8'd8, 36'sh7_FFFF_FFFF);
    host_read(8'd7, rd, lat);
    check_val("rd7_sat", rd, PEAK_MAX);
    host_read(8'd8, rd, lat);
    check_val("rd8_max", rd, PEAK_MAX);
    tick();

    // request during a 10-cycle burst to addr 9
    for (int i = 0; i < 10; i++) begin
      aux_in_en = 1'b1; aux_in_addr = 8'd9; aux_in_data = 36'sd500;
      if (i == 2) begin
        check_val("burst_ready", host_rd_ready, 1);
        host_rd_req = 1'b1; host_rd_addr = 8'd9;
      end
      if (i == 5) begin
        check_val("burst_pending_ready", host_rd_ready, 0);
        check_val("burst_pending_ack", host_rd_ack, 0);
      end
      tick();
      host_rd_req = 1'b0;
    end
    aux_in_en = 1'b0;                 // cycle c: first idle slot
    check_val("burst_ack_c", host_rd_ack, 0);
    tick();                           // c+1: write lands in next period
    check_val("burst_ack_c1", host_rd_ack, 0);
    aux_in_en = 1'b1; aux_in_addr = 8'd9; aux_in_data = 36'sd40;
    tick();                           // c+2
    aux_in_en = 1'b0;
    check_val("burst_ack_c2", host_rd_ack, 1);
    check_val("burst_data", host_rd_data, 500);
    host_read(8'd9, rd, lat);
    check_val("rd9_next", rd, 40);
    tick();

    // clear_all with data present, aux write during the sweep
    aux_write(8'd2, 36'sd700);
    tick();
    tick();
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      aux_in_en = (n == 10); aux_in_addr = 8'd4; aux_in_data = 36'sd900;
      n++;
      tick();
    end
    aux_in_en = 1'b0;
    check_val("clr_busy_cycles", n, 256);
    check_val("clr_dropped", aux_dropped, 1);
    host_read(8'd2, rd, lat);
    check_val("clr_rd2", rd, 0);
    host_read(8'd4, rd, lat);
    check_val("clr_rd4_discarded", rd, 0);
    tick();
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    check_val("clr2_dropped", aux_dropped, 0);
    check_val("clr2_busy", busy, 1);
    n = 0;
    while (busy && n < 400) begin
      n++;
      tick();
    end
    check_val("clr2_busy_cycles", n, 256);

    // reset one cycle after an accepted request
    aux_write(8'd11, 36'sd123);
    host_read(8'd11, rd, lat);
    check_val("rd11_data", rd, 123);
    tick();
    aux_write(8'd11, 36'sd77);
    host_rd_req = 1'b1; host_rd_addr = 8'd11;
    tick();
    host_rd_req = 1'b0;
    reset = 1'b1;
    #1;
    check_val("mid_rst_ack", host_rd_ack, 0);
    check_val("mid_rst_data", host_rd_data, 0);
    check_val("mid_rst_busy", busy, 1);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (host_rd_ack) acks++;
    end
    reset = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      if (host_rd_ack) acks++;
      if (host_rd_ready) acks++;
      n++;
      tick();
    end
    check_val("mid_rst_no_ack", acks, 0);
    check_val("mid_rst_sweep", n, 256);
    check_val("mid_rst_ready", host_rd_ready, 1);
    host_read(8'd11, rd, lat);
    check_val("mid_rst_rd11", rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
